// File: rtl/prm_sweep_pkg.sv
// Shared types and default geometry for the PRM LUT sweep sequencer.
package prm_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

  localparam int unsigned DEF_XW    = 3;
  localparam int unsigned DEF_YW    = 4;
  localparam int unsigned DEF_ZW    = 4;
  localparam int unsigned DEF_BANKS = 8;
  localparam int unsigned DEF_MASKW = 512;
  localparam int unsigned DEF_CNTW  = 32;

  localparam int unsigned DEF_NCOORD = 2 ** (DEF_XW + DEF_YW + DEF_ZW);

endpackage

// File: rtl/prm_mask_pick.sv
// Pipeline stage 1 of the sweep: registers one selected mask bit out of the
// concatenated LUT bank masks, together with a qualifying valid flag.
module prm_mask_pick #(
  parameter int unsigned BANKS = 8,
  parameter int unsigned MASKW = 512
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [BANKS*MASKW-1:0]     mask_i,
  input  logic [$clog2(BANKS)-1:0]   bank_i,
  input  logic [$clog2(MASKW)-1:0]   bit_i,
  input  logic                       sample_i,
  output logic                       hit_o,
  output logic                       valid_o
);

  localparam int unsigned IW = $clog2(BANKS * MASKW);

  logic [IW-1:0] idx;
  logic          hit_d;
  logic          hit_q;
  logic          valid_q;

  assign idx   = IW'(bank_i) * IW'(MASKW) + IW'(bit_i);
  assign hit_d = mask_i[idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      hit_q   <= hit_d;
      valid_q <= sample_i;
    end
  end

  assign hit_o   = hit_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/prm_sweep_ctrl.sv
// Sweeps every {x,y,z} LUT coordinate and counts hits on one selected mask bit.
// Optional first-hit capture is built only when PRM_SWEEP_FIRSTHIT_EN is defined.
module prm_sweep_ctrl
  import prm_sweep_pkg::*;
#(
  parameter int unsigned XW    = DEF_XW,
  parameter int unsigned YW    = DEF_YW,
  parameter int unsigned ZW    = DEF_ZW,
  parameter int unsigned BANKS = DEF_BANKS,
  parameter int unsigned MASKW = DEF_MASKW,
  parameter int unsigned CNTW  = DEF_CNTW
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic                     abort,
  input  logic [$clog2(BANKS)-1:0] bank_sel,
  input  logic [$clog2(MASKW)-1:0] bit_sel,
  input  logic [BANKS*MASKW-1:0]   edge_mask_all,
  output logic [XW-1:0]            x,
  output logic [YW-1:0]            y,
  output logic [ZW-1:0]            z,
  output logic                     busy,
  output logic                     done,
  output logic [CNTW-1:0]          hit_count,
  output logic [XW+YW+ZW-1:0]      first_xyz,
  output logic                     first_valid
);

  localparam int unsigned N   = XW + YW + ZW;
  localparam int unsigned BSW = $clog2(BANKS);
  localparam int unsigned BTW = $clog2(MASKW);

  sweep_state_t   state_q, state_d;
  logic [N-1:0]   coord_q, coord_d;
  logic [BSW-1:0] bank_q, bank_d;
  logic [BTW-1:0] bit_q, bit_d;
  logic [CNTW-1:0] hit_q, hit_d;
  logic           accept;
  logic           sample;
  logic           pick_hit;
  logic           pick_valid;

  // Abort always has priority over the coordinate walk; start is only heard when not busy.
  always_comb begin
    state_d = state_q;
    coord_d = coord_q;
    bank_d  = bank_q;
    bit_d   = bit_q;
    accept  = 1'b0;
    sample  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SWEEP;
          coord_d = '0;
          bank_d  = bank_sel;
          bit_d   = bit_sel;
        end
      end
      ST_SWEEP: begin
        if (abort) begin
          state_d = ST_IDLE;
          coord_d = '0;
        end else begin
          sample = 1'b1;
          if (coord_q == '1) begin
            state_d = ST_DRAIN;
            coord_d = '0;
          end else begin
            coord_d = coord_q + N'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (abort) state_d = ST_IDLE;
        else       state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hit_d = hit_q;
    if (accept) begin
      hit_d = '0;
    end else if (pick_valid && pick_hit && (hit_q != '1)) begin
      hit_d = hit_q + CNTW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      coord_q <= '0;
      bank_q  <= '0;
      bit_q   <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      coord_q <= coord_d;
      bank_q  <= bank_d;
      bit_q   <= bit_d;
      hit_q   <= hit_d;
    end
  end

  prm_mask_pick #(
    .BANKS (BANKS),
    .MASKW (MASKW)
  ) u_pick (
    .clk_i    (CLK),
    .rst_i    (RST),
    .mask_i   (edge_mask_all),
    .bank_i   (bank_q),
    .bit_i    (bit_q),
    .sample_i (sample),
    .hit_o    (pick_hit),
    .valid_o  (pick_valid)
  );

  assign {x, y, z}  = (state_q == ST_SWEEP) ? coord_q : '0;
  assign busy       = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign hit_count  = hit_q;

`ifdef PRM_SWEEP_FIRSTHIT_EN
  // Coordinate is delayed one cycle so it lines up with the stage-1 pick result.
  logic [N-1:0] coord_s1_q;
  logic [N-1:0] first_q, first_d;
  logic         fvalid_q, fvalid_d;

  always_comb begin
    first_d  = first_q;
    fvalid_d = fvalid_q;
    if (accept) begin
      first_d  = '0;
      fvalid_d = 1'b0;
    end else if (pick_valid && pick_hit && !fvalid_q) begin
      first_d  = coord_s1_q;
      fvalid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      coord_s1_q <= '0;
      first_q    <= '0;
      fvalid_q   <= 1'b0;
    end else begin
      coord_s1_q <= coord_q;
      first_q    <= first_d;
      fvalid_q   <= fvalid_d;
    end
  end

  assign first_xyz   = first_q;
  assign first_valid = fvalid_q;
`else
  assign first_xyz   = '0;
  assign first_valid = 1'b0;
`endif

endmodule

// File: tb/tb_prm_sweep_ctrl.sv
// Self-checking bench for prm_sweep_ctrl: full sweeps from a vector table with a
// scoreboard, plus abort, busy-start and mid-sweep reset sequences.
module tb_prm_sweep_ctrl;
  import prm_sweep_pkg::*;

  localparam int BANKS = 8;
  localparam int MASKW = 512;
  localparam int N     = 11;
  localparam int LAT   = DEF_NCOORD + 1;

`ifdef PRM_SWEEP_FIRSTHIT_EN
  localparam bit FH_EN = 1'b1;
`else
  localparam bit FH_EN = 1'b0;
`endif

  logic                   CLK;
  logic                   RST;
  logic                   start;
  logic                   abort;
  logic [2:0]             bank_sel;
  logic [8:0]             bit_sel;
  logic [BANKS*MASKW-1:0] mask;
  logic [2:0]             x, x8;
  logic [3:0]             y, y8;
  logic [3:0]             z, z8;
  logic                   busy, busy8, done, done8;
  logic [31:0]            hit_count;
  logic [7:0]             hit8;
  logic [N-1:0]           first_xyz, first8;
  logic                   first_valid, fv8;

  int pattern;
  int patBank;
  int patBit;
  int nChecks;
  int nErrors;

  typedef struct {
    int           pat;
    int           bk;
    int           bt;
    int           hit;
    bit           fv;
    logic [N-1:0] fxyz;
    int           poke;
  } vec_t;

  typedef struct {
    int           hit;
    int           hit8;
    bit           fv;
    logic [N-1:0] fxyz;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];

  prm_sweep_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .bank_sel(bank_sel), .bit_sel(bit_sel), .edge_mask_all(mask),
    .x(x), .y(y), .z(z), .busy(busy), .done(done), .hit_count(hit_count),
    .first_xyz(first_xyz), .first_valid(first_valid)
  );

  prm_sweep_ctrl #(.CNTW(8)) dut8 (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .bank_sel(bank_sel), .bit_sel(bit_sel), .edge_mask_all(mask),
    .x(x8), .y(y8), .z(z8), .busy(busy8), .done(done8), .hit_count(hit8),
    .first_xyz(first8), .first_valid(fv8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // LUT bank model: mask bits are a function of the presented coordinate, with
  // decoy bits in the neighbouring bank and bit to catch mis-indexing.
  always_comb begin
    mask = '0;
    case (pattern)
      1: mask[3*MASKW +: MASKW] = '1;
      2: if ({x, y, z} == 11'h7FF) mask[7*MASKW + 511] = 1'b1;
      3, 4, 5: begin
        mask[patBank*MASKW + patBit + 1]   = 1'b1;
        mask[(patBank-1)*MASKW + patBit]   = 1'b1;
        if ((pattern == 3 && z[0]) ||
            (pattern == 4 && x == 3'd5) ||
            (pattern == 5 && y == 4'd9 && z == 4'd3))
          mask[patBank*MASKW + patBit] = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " xyz"},   {x, y, z}, 0);
    checkOutput({tag, " busy"},  busy, 0);
    checkOutput({tag, " done"},  done, 0);
    checkOutput({tag, " hit"},   hit_count, 0);
    checkOutput({tag, " hit8"},  hit8, 0);
    checkOutput({tag, " fv"},    first_valid, 0);
    checkOutput({tag, " first"}, first_xyz, 0);
  endtask

  task automatic startSweep(input int pat, input int bk, input int bt, input bit withAbort);
    pattern  = pat;
    patBank  = bk;
    patBit   = bt;
    bank_sel = 3'(bk);
    bit_sel  = 9'(bt);
    start    = 1'b1;
    abort    = withAbort;
    @(posedge CLK);
    #1;
    start    = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int cyc;
    int busyCnt;
    int coordErr;
    e.hit  = v.hit;
    e.hit8 = (v.hit > 255) ? 255 : v.hit;
    e.fv   = FH_EN & v.fv;
    e.fxyz = FH_EN ? v.fxyz : '0;
    sbq.push_back(e);
    startSweep(v.pat, v.bk, v.bt, 1'b0);
    bank_sel = ~bank_sel;
    bit_sel  = ~bit_sel;
    checkOutput("done drop", done, 0);
    busyCnt  = busy ? 1 : 0;
    coordErr = 0;
    cyc      = 0;
    while (cyc < 3000 && !done) begin
      if (cyc < DEF_NCOORD && {x, y, z} != N'(cyc)) coordErr++;
      if (cyc == DEF_NCOORD && {x, y, z} != '0) coordErr++;
      if ({x8, y8, z8, busy8} != {x, y, z, busy}) coordErr++;
      start = (v.poke != 0 && cyc == v.poke);
      @(posedge CLK);
      #1;
      cyc++;
      if (busy) busyCnt++;
    end
    start = 1'b0;
    e = sbq.pop_front();
    checkOutput("latency",     cyc, LAT);
    checkOutput("busy cycles", busyCnt, LAT);
    checkOutput("coord seq",   coordErr, 0);
    checkOutput("hit_count",   hit_count, e.hit);
    checkOutput("hit8 sat",    hit8, e.hit8);
    checkOutput("done8",       done8, 1);
    checkOutput("first_valid", first_valid, e.fv);
    checkOutput("first_xyz",   first_xyz, e.fxyz);
    checkOutput("dut8 first",  {fv8, first8}, {e.fv, e.fxyz});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks  = 0;
    nErrors  = 0;
    pattern  = 0;
    patBank  = 0;
    patBit   = 0;
    RST      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    bank_sel = '0;
    bit_sel  = '0;

    vecs[0] = '{pat:0, bk:0, bt:0,   hit:0,    fv:0, fxyz:11'h000, poke:0};
    vecs[1] = '{pat:1, bk:3, bt:100, hit:2048, fv:1, fxyz:11'h000, poke:499};
    vecs[2] = '{pat:2, bk:7, bt:511, hit:1,    fv:1, fxyz:11'h7FF, poke:0};
    vecs[3] = '{pat:1, bk:2, bt:100, hit:0,    fv:0, fxyz:11'h000, poke:0};
    vecs[4] = '{pat:3, bk:5, bt:37,  hit:1024, fv:1, fxyz:11'h001, poke:0};
    vecs[5] = '{pat:4, bk:6, bt:200, hit:256,  fv:1, fxyz:11'h500, poke:0};
    vecs[6] = '{pat:5, bk:2, bt:510, hit:8,    fv:1, fxyz:11'h093, poke:0};

    waitEdges(3);
    checkIdleZero("reset");
    RST = 1'b0;
    waitEdges(1);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    abort = 1'b1;
    waitEdges(1);
    abort = 1'b0;
    checkOutput("abort in DONE done", done, 1);
    checkOutput("abort in DONE busy", busy, 0);
    checkOutput("abort in DONE hit",  hit_count, 8);

    startSweep(3, 5, 37, 1'b0);
    waitEdges(100);
    abort = 1'b1;
    waitEdges(1);
    abort = 1'b0;
    checkOutput("abort zodd busy", busy, 0);
    checkOutput("abort zodd done", done, 0);
    checkOutput("abort zodd hit",  hit_count, 50);
    checkOutput("abort zodd xyz",  {x, y, z}, 0);

    startSweep(1, 3, 100, 1'b1);
    checkOutput("start wins idle", busy, 1);
    waitEdges(100);
    abort = 1'b1;
    start = 1'b1;
    waitEdges(1);
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort wins busy", busy, 0);
    checkOutput("abort ones hit",  hit_count, 100);
    waitEdges(3);
    checkOutput("abort flush hit", hit_count, 100);
    checkOutput("abort stays idle", {busy, done}, 0);

    startSweep(1, 3, 100, 1'b0);
    waitEdges(999);
    RST = 1'b1;
    waitEdges(1);
    checkIdleZero("mid reset");
    RST = 1'b0;
    waitEdges(1);
    applyStimulus(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
